// File: rtl/cccp_lut_access_arb.sv
// Arbitrates host and engine access to a shared CCCP lookup table, keeping one
// table operation in flight, with per-operation timeout and a whole-table clear.
module cccp_lut_access_arb #(
    parameter int NUM_QUEUES     = 8,
    parameter int NAME_LENTH     = 32,
    parameter int VN_LENTH       = 16,
    parameter int LUT_DEPTH      = 32,
    parameter int LUT_DEPTH_BITS = 5,
    parameter int TIMEOUT        = 64,
    parameter int ENTRY_W        = NUM_QUEUES + 32 + NAME_LENTH + VN_LENTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      h_req,
    input  logic                      h_wr,
    input  logic [LUT_DEPTH_BITS-1:0] h_addr,
    input  logic [ENTRY_W-1:0]        h_wdata,
    output logic                      h_ack,
    input  logic                      e_req,
    input  logic                      e_wr,
    input  logic [LUT_DEPTH_BITS-1:0] e_addr,
    input  logic [ENTRY_W-1:0]        e_wdata,
    output logic                      e_ack,
    output logic [ENTRY_W-1:0]        rsp_rdata,
    output logic                      rsp_err,
    input  logic                      clr_req,
    output logic                      clr_busy,
    output logic                      timeout_flag,
    output logic [LUT_DEPTH_BITS-1:0] lut_rd_addr,
    output logic                      lut_rd_req,
    input  logic [ENTRY_W-1:0]        lut_rd_data,
    input  logic                      lut_rd_ack,
    output logic [LUT_DEPTH_BITS-1:0] lut_wr_addr,
    output logic                      lut_wr_req,
    output logic [ENTRY_W-1:0]        lut_wr_data,
    input  logic                      lut_wr_ack
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0]          TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [LUT_DEPTH_BITS-1:0] ADDR_LAST = LUT_DEPTH_BITS'(LUT_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CLR_ISSUE,
        CLR_WAIT
    } state_t;

    state_t                      state_reg, state_next;
    logic                        last_host_reg, last_host_next;
    logic                        gnt_host_reg, gnt_host_next;
    logic                        op_wr_reg, op_wr_next;
    logic [LUT_DEPTH_BITS-1:0]   addr_reg, addr_next;
    logic [ENTRY_W-1:0]          wdata_reg, wdata_next;
    logic [TMR_W-1:0]            timer_reg, timer_next;
    logic                        clr_busy_reg, clr_busy_next;
    logic [LUT_DEPTH_BITS-1:0]   clr_addr_reg, clr_addr_next;
    logic                        h_ack_reg, h_ack_next;
    logic                        e_ack_reg, e_ack_next;
    logic [ENTRY_W-1:0]          rdata_reg, rdata_next;
    logic                        err_reg, err_next;
    logic                        tflag_reg, tflag_next;

    logic h_elig;
    logic e_elig;
    logic pick_host;
    logic ack_hit;

    // A requester being acked this cycle is still holding its level request.
    assign h_elig    = h_req && !h_ack_reg;
    assign e_elig    = e_req && !e_ack_reg;
    assign pick_host = h_elig && (!e_elig || !last_host_reg);
    assign ack_hit   = op_wr_reg ? lut_wr_ack : lut_rd_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            last_host_reg <= 1'b0;
            gnt_host_reg  <= 1'b0;
            op_wr_reg     <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            timer_reg     <= '0;
            clr_busy_reg  <= 1'b0;
            clr_addr_reg  <= '0;
            h_ack_reg     <= 1'b0;
            e_ack_reg     <= 1'b0;
            rdata_reg     <= '0;
            err_reg       <= 1'b0;
            tflag_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            last_host_reg <= last_host_next;
            gnt_host_reg  <= gnt_host_next;
            op_wr_reg     <= op_wr_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            timer_reg     <= timer_next;
            clr_busy_reg  <= clr_busy_next;
            clr_addr_reg  <= clr_addr_next;
            h_ack_reg     <= h_ack_next;
            e_ack_reg     <= e_ack_next;
            rdata_reg     <= rdata_next;
            err_reg       <= err_next;
            tflag_reg     <= tflag_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        last_host_next = last_host_reg;
        gnt_host_next  = gnt_host_reg;
        op_wr_next     = op_wr_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        timer_next     = timer_reg;
        clr_busy_next  = clr_busy_reg;
        clr_addr_next  = clr_addr_reg;
        h_ack_next     = 1'b0;
        e_ack_next     = 1'b0;
        rdata_next     = '0;
        err_next       = 1'b0;
        tflag_next     = tflag_reg;

        if (clr_req && !clr_busy_reg) begin
            clr_busy_next = 1'b1;
            clr_addr_next = '0;
        end

        unique case (state_reg)
            IDLE: begin
                if (clr_busy_reg) begin
                    state_next = CLR_ISSUE;
                end else if (h_elig || e_elig) begin
                    state_next     = ISSUE;
                    gnt_host_next  = pick_host;
                    last_host_next = pick_host;
                    op_wr_next     = pick_host ? h_wr    : e_wr;
                    addr_next      = pick_host ? h_addr  : e_addr;
                    wdata_next     = pick_host ? h_wdata : e_wdata;
                end
            end
            ISSUE: begin
                timer_next = '0;
                state_next = WAIT;
            end
            WAIT: begin
                if (ack_hit || timer_reg == TMR_LAST) begin
                    state_next = IDLE;
                    h_ack_next = gnt_host_reg;
                    e_ack_next = !gnt_host_reg;
                    if (ack_hit) begin
                        rdata_next = op_wr_reg ? '0 : lut_rd_data;
                    end else begin
                        err_next   = 1'b1;
                        tflag_next = 1'b1;
                    end
                end else begin
                    timer_next = timer_reg + TMR_W'(1);
                end
            end
            CLR_ISSUE: begin
                timer_next = '0;
                state_next = CLR_WAIT;
            end
            CLR_WAIT: begin
                // A timed-out clear write is flagged but the sweep carries on.
                if (lut_wr_ack || timer_reg == TMR_LAST) begin
                    if (!lut_wr_ack) begin
                        tflag_next = 1'b1;
                    end
                    if (clr_addr_reg == ADDR_LAST) begin
                        clr_busy_next = 1'b0;
                        state_next    = IDLE;
                    end else begin
                        clr_addr_next = clr_addr_reg + LUT_DEPTH_BITS'(1);
                        state_next    = CLR_ISSUE;
                    end
                end else begin
                    timer_next = timer_reg + TMR_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign lut_rd_req   = (state_reg == ISSUE) && !op_wr_reg;
    assign lut_wr_req   = ((state_reg == ISSUE) && op_wr_reg) || (state_reg == CLR_ISSUE);
    assign lut_rd_addr  = lut_rd_req ? addr_reg : '0;
    assign lut_wr_addr  = (state_reg == CLR_ISSUE) ? clr_addr_reg :
                          (lut_wr_req ? addr_reg : '0);
    assign lut_wr_data  = ((state_reg == ISSUE) && op_wr_reg) ? wdata_reg : '0;

    assign h_ack        = h_ack_reg;
    assign e_ack        = e_ack_reg;
    assign rsp_rdata    = rdata_reg;
    assign rsp_err      = err_reg;
    assign clr_busy     = clr_busy_reg;
    assign timeout_flag = tflag_reg;

endmodule

// File: tb/tb_cccp_lut_access_arb.sv
// Directed bench for cccp_lut_access_arb with a delay-programmable table responder.
module tb_cccp_lut_access_arb;

    localparam int W  = 88;
    localparam int AW = 5;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          h_req = 1'b0, h_wr = 1'b0;
    logic [AW-1:0] h_addr = '0;
    logic [W-1:0]  h_wdata = '0;
    logic          h_ack;
    logic          e_req = 1'b0, e_wr = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [W-1:0]  e_wdata = '0;
    logic          e_ack;
    logic [W-1:0]  rsp_rdata;
    logic          rsp_err;
    logic          clr_req = 1'b0;
    logic          clr_busy, timeout_flag;
    logic [AW-1:0] lut_rd_addr, lut_wr_addr;
    logic          lut_rd_req, lut_wr_req;
    logic [W-1:0]  lut_rd_data = '0;
    logic          lut_rd_ack = 1'b0, lut_wr_ack = 1'b0;
    logic [W-1:0]  lut_wr_data;

    cccp_lut_access_arb dut (
        .clk(clk), .reset(reset),
        .h_req(h_req), .h_wr(h_wr), .h_addr(h_addr), .h_wdata(h_wdata), .h_ack(h_ack),
        .e_req(e_req), .e_wr(e_wr), .e_addr(e_addr), .e_wdata(e_wdata), .e_ack(e_ack),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .clr_req(clr_req), .clr_busy(clr_busy), .timeout_flag(timeout_flag),
        .lut_rd_addr(lut_rd_addr), .lut_rd_req(lut_rd_req), .lut_rd_data(lut_rd_data),
        .lut_rd_ack(lut_rd_ack),
        .lut_wr_addr(lut_wr_addr), .lut_wr_req(lut_wr_req), .lut_wr_data(lut_wr_data),
        .lut_wr_ack(lut_wr_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Table responder: acks a request a programmable number of cycles later.
    int           rd_delay = 3, wr_delay = 1;
    bit           rd_en = 0, wr_en = 0;
    int           rd_cnt = 0, wr_cnt = 0;
    int           inj_rd = 0, inj_rd_seen = 0, inj_wr = 0, inj_wr_seen = 0;
    logic [W-1:0] rd_val = '0;

    always @(posedge clk) begin
        #1;
        lut_rd_ack = 1'b0;
        lut_wr_ack = 1'b0;
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) lut_rd_ack = 1'b1;
        end
        if (wr_cnt > 0) begin
            wr_cnt--;
            if (wr_cnt == 0) lut_wr_ack = 1'b1;
        end
        if (lut_rd_req && rd_en) rd_cnt = rd_delay;
        if (lut_wr_req && wr_en) wr_cnt = wr_delay;
        if (inj_rd != inj_rd_seen) begin
            lut_rd_ack  = 1'b1;
            inj_rd_seen = inj_rd;
        end
        if (inj_wr != inj_wr_seen) begin
            lut_wr_ack  = 1'b1;
            inj_wr_seen = inj_wr;
        end
        lut_rd_data = lut_rd_ack ? rd_val : ~rd_val;
    end

    // Monitor: sampled mid-cycle.
    int            n_rd_req = 0, n_wr_req = 0, n_h_ack = 0, n_e_ack = 0;
    int            rd_req_cyc = 0, wr_req_cyc = 0, ack_cyc = 0;
    int            last_wr_ack_cyc = 0, clr_fall_cyc = 0, viol = 0;
    logic [AW-1:0] last_rd_addr = '0;
    logic [W-1:0]  ack_rdata = '0;
    logic          ack_err = 1'b0;
    bit            pend = 0, clr_prev = 0;
    bit            who_q[$];
    logic [AW-1:0] wa_q[$];
    logic [W-1:0]  wd_q[$];

    always @(negedge clk) begin
        if (lut_rd_req) begin
            n_rd_req++;
            rd_req_cyc   = cyc;
            last_rd_addr = lut_rd_addr;
            if (pend) viol++;
            pend = 1;
        end
        if (lut_wr_req) begin
            n_wr_req++;
            wr_req_cyc = cyc;
            wa_q.push_back(lut_wr_addr);
            wd_q.push_back(lut_wr_data);
            if (pend) viol++;
            pend = 1;
        end
        if (lut_rd_ack || lut_wr_ack) pend = 0;
        if (lut_wr_ack) last_wr_ack_cyc = cyc;
        if (h_ack || e_ack) begin
            ack_cyc   = cyc;
            ack_rdata = rsp_rdata;
            ack_err   = rsp_err;
            pend      = 0;
        end
        if (h_ack) begin
            n_h_ack++;
            who_q.push_back(1'b1);
        end
        if (e_ack) begin
            n_e_ack++;
            who_q.push_back(1'b0);
        end
        if (clr_prev && !clr_busy) clr_fall_cyc = cyc;
        clr_prev = clr_busy;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_i(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_w(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_i({tag, "_h_ack"},   int'(h_ack), 0);
        check_i({tag, "_e_ack"},   int'(e_ack), 0);
        check_w({tag, "_rdata"},   rsp_rdata, '0);
        check_i({tag, "_err"},     int'(rsp_err), 0);
        check_i({tag, "_clrbusy"}, int'(clr_busy), 0);
        check_i({tag, "_tflag"},   int'(timeout_flag), 0);
        check_i({tag, "_rdreq"},   int'(lut_rd_req), 0);
        check_i({tag, "_wrreq"},   int'(lut_wr_req), 0);
        check_i({tag, "_rdaddr"},  int'(lut_rd_addr), 0);
    endtask

    initial begin
        bit got;
        int hb, eb, rb, wb, wbase, qb, vb, bad;

        // Reset state
        repeat (3) tick();
        check_idle_outputs("rst_held");
        reset = 1'b0;
        tick();
        check_idle_outputs("rst_rel");

        // Host read of address 5, table acks 3 cycles after the request
        rd_en = 1; rd_delay = 3;
        rd_val = 88'hABCDEF0123456789ABCDEF;
        hb = n_h_ack; rb = n_rd_req;
        h_wr = 1'b0; h_addr = 5'd5; h_req = 1'b1;
        got = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (n_h_ack != hb) begin got = 1; break; end
        end
        h_req = 1'b0;
        check_i("rd_ack_seen", int'(got), 1);
        check_i("rd_req_count", n_rd_req - rb, 1);
        check_i("rd_addr", int'(last_rd_addr), 5);
        check_i("rd_ack_latency", ack_cyc - rd_req_cyc, 4);
        check_w("rd_data", ack_rdata, 88'hABCDEF0123456789ABCDEF);
        check_i("rd_err", int'(ack_err), 0);
        tick();
        check_i("rd_ack_pulse", int'(h_ack), 0);

        // Both writers held from reset: alternate host, engine, host, engine
        rd_en = 0; wr_en = 1; wr_delay = 2;
        reset = 1'b1;
        h_wr = 1'b1; e_wr = 1'b1; h_addr = 5'd1; e_addr = 5'd2;
        h_wdata = 88'h1111_2222_3333_4444_5555_66;
        e_wdata = 88'hAAAA_BBBB_CCCC_DDDD_EEEE_FF;
        h_req = 1'b1; e_req = 1'b1;
        tick(); tick();
        qb = who_q.size(); wbase = wa_q.size(); vb = viol;
        reset = 1'b0;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (who_q.size() - qb >= 4) begin got = 1; break; end
        end
        h_req = 1'b0; e_req = 1'b0;
        check_i("rr_four_acks", int'(got), 1);
        check_i("rr_grant0_host", int'(who_q[qb]), 1);
        check_i("rr_grant1_eng", int'(who_q[qb+1]), 0);
        check_i("rr_grant2_host", int'(who_q[qb+2]), 1);
        check_i("rr_grant3_eng", int'(who_q[qb+3]), 0);
        check_w("rr_wdata0", wd_q[wbase], 88'h1111_2222_3333_4444_5555_66);
        check_w("rr_wdata1", wd_q[wbase+1], 88'hAAAA_BBBB_CCCC_DDDD_EEEE_FF);
        check_i("rr_waddr1", int'(wa_q[wbase+1]), 2);
        check_i("rr_no_overlap", viol - vb, 0);

        // Write with no table ack times out
        wr_en = 0;
        tick(); tick();
        hb = n_h_ack; eb = n_e_ack;
        h_wr = 1'b1; h_addr = 5'd9; h_req = 1'b1;
        got = 0;
        for (int i = 0; i < TO + 20; i++) begin
            tick();
            if (n_h_ack != hb) begin got = 1; break; end
        end
        h_req = 1'b0;
        check_i("to_ack_seen", int'(got), 1);
        check_i("to_latency", ack_cyc - wr_req_cyc, TO + 1);
        check_i("to_err", int'(ack_err), 1);
        check_w("to_rdata", ack_rdata, '0);
        check_i("to_flag", int'(timeout_flag), 1);
        inj_wr++;
        repeat (4) tick();
        check_i("to_late_ack_h", n_h_ack, hb + 1);
        check_i("to_late_ack_e", n_e_ack, eb);
        check_i("to_flag_sticky", int'(timeout_flag), 1);

        // Read ack during a write is the wrong type and must not complete it
        wr_en = 1; wr_delay = 6;
        hb = n_h_ack; wb = n_wr_req;
        h_addr = 5'd4; h_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (n_wr_req != wb) break;
        end
        inj_rd++;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (n_h_ack != hb) begin got = 1; break; end
        end
        h_req = 1'b0;
        check_i("wt_ack_seen", int'(got), 1);
        check_i("wt_latency", ack_cyc - wr_req_cyc, 7);
        check_i("wt_err", int'(ack_err), 0);

        // Clear requested during an engine write; host read held meanwhile
        tick(); tick();
        wr_delay = 1; rd_en = 1; rd_delay = 2;
        rd_val = 88'h123456789ABCDEF0123456;
        eb = n_e_ack; hb = n_h_ack; wb = n_wr_req;
        e_wr = 1'b1; e_addr = 5'd3; e_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (n_wr_req != wb) break;
        end
        wbase = wa_q.size();
        clr_req = 1'b1;
        h_wr = 1'b0; h_addr = 5'd12; h_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check_i("clr_busy_set", int'(clr_busy), 1);
        got = 0;
        for (int i = 0; i < 10; i++) begin
            if (n_e_ack != eb) begin got = 1; break; end
            tick();
        end
        e_req = 1'b0;
        check_i("clr_eng_acked", int'(got), 1);
        check_i("clr_eng_first", wa_q.size() - wbase, 0);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!clr_busy) break;
            tick();
        end
        check_i("clr_done", int'(clr_busy), 0);
        check_i("clr_host_stalled", n_h_ack, hb);
        check_i("clr_write_count", wa_q.size() - wbase, 32);
        bad = 0;
        for (int i = 0; i < 32 && wbase + i < wa_q.size(); i++) begin
            if (int'(wa_q[wbase+i]) != i || wd_q[wbase+i] !== '0) bad++;
        end
        check_i("clr_addr_data", bad, 0);
        check_i("clr_fall_timing", clr_fall_cyc, last_wr_ack_cyc + 1);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (n_h_ack != hb) begin got = 1; break; end
        end
        h_req = 1'b0;
        check_i("clr_host_served", int'(got), 1);
        check_w("clr_host_rdata", ack_rdata, 88'h123456789ABCDEF0123456);

        // Reset while waiting on a read ack
        tick(); tick();
        rd_en = 0;
        hb = n_h_ack; eb = n_e_ack; rb = n_rd_req;
        h_wr = 1'b0; h_addr = 5'd7; h_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (n_rd_req != rb) break;
        end
        tick(); tick();
        reset = 1'b1; h_req = 1'b0;
        tick();
        check_idle_outputs("rst_wait");
        reset = 1'b0;
        inj_rd++;
        repeat (5) tick();
        check_i("rst_no_h_ack", n_h_ack, hb);
        check_i("rst_no_e_ack", n_e_ack, eb);
        check_i("rst_no_reissue", n_rd_req, rb + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
